// File: rtl/serial_deser_pkg.sv
// serial_deser_pkg: shared types, defaults and helpers for the serial deserializer
package serial_deser_pkg;
  typedef enum logic {S_DATA, S_PAR} deser_state_e;
  localparam int DESER_WIDTH_DEF = 8;
  function automatic int cnt_width(int w);
    return $clog2(w + 1);
  endfunction
endpackage

// File: rtl/deser_shifter.sv
// deser_shifter: WIDTH-bit serial-in shift register, MSB- or LSB-first, with optional look-ahead output
module deser_shifter #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit LOOKAHEAD = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift_en,
  input  logic             clr,
  input  logic             d,
  output logic [WIDTH-1:0] word
);
  logic [WIDTH-1:0] q, nxt;
  assign nxt  = MSB_FIRST ? {q[WIDTH-2:0], d} : {d, q[WIDTH-1:1]};
  assign word = LOOKAHEAD ? nxt : q;
  // shift register: clear has priority over shift, idle edges hold the partial word
  always_ff @(posedge clk or negedge rst)
    if (!rst) q <= '0;
    else if (clr) q <= '0;
    else if (shift_en) q <= nxt;
endmodule

// File: rtl/serial_deser.sv
// serial_deser: serial-to-parallel word assembler with valid/ready output; SERIAL_DESER_PARITY_EN adds an even-parity bit per frame
module serial_deser
  import serial_deser_pkg::*;
#(
  parameter int WIDTH     = DESER_WIDTH_DEF,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             d,
  input  logic             en,
  input  logic             sync_clr,
  output logic [WIDTH-1:0] data_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overflow,
  output logic             parity_err
);
  localparam int CW = cnt_width(WIDTH);
`ifdef SERIAL_DESER_PARITY_EN
  localparam bit LOOKAHEAD = 1'b0;
`else
  localparam bit LOOKAHEAD = 1'b1;
`endif
  deser_state_e state, state_next;
  logic [CW-1:0] bit_cnt;
  logic [WIDTH-1:0] word;
  logic take, shift_en, last_data, done, word_perr, load, xfer;
  deser_shifter #(.WIDTH(WIDTH), .MSB_FIRST(MSB_FIRST), .LOOKAHEAD(LOOKAHEAD)) u_shifter (
    .clk, .rst, .shift_en, .clr(sync_clr), .d, .word
  );
  // FSM state register
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= S_DATA;
    else state <= state_next;
  // next state: the parity state follows the last data bit and only exists in the parity build
  always_comb begin
`ifdef SERIAL_DESER_PARITY_EN
    state_next = sync_clr ? S_DATA : last_data ? S_PAR : done ? S_DATA : state;
`else
    state_next = S_DATA;
`endif
  end
  // per-edge decodes: data shift, frame completion and parity of the completed frame
  always_comb begin
    take      = en && !sync_clr;
    shift_en  = take && state == S_DATA;
    last_data = shift_en && bit_cnt == CW'(WIDTH - 1);
`ifdef SERIAL_DESER_PARITY_EN
    done      = take && state == S_PAR;
    word_perr = ^{word, d};
`else
    done      = last_data;
    word_perr = 1'b0;
`endif
    xfer      = out_valid && out_ready;
    load      = done && (!out_valid || out_ready);
  end
  // bit counter wraps at the last data bit so back-to-back words stay aligned
  always_ff @(posedge clk or negedge rst)
    if (!rst) bit_cnt <= '0;
    else if (sync_clr) bit_cnt <= '0;
    else if (shift_en) bit_cnt <= last_data ? '0 : bit_cnt + 1'b1;
  // output holding register: new word loads when the slot is free or being drained this edge
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      data_out   <= '0;
      out_valid  <= 1'b0;
      parity_err <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      data_out   <= load ? word : data_out;
      parity_err <= load ? word_perr : parity_err;
      out_valid  <= load ? 1'b1 : xfer ? 1'b0 : out_valid;
      overflow   <= sync_clr ? 1'b0 : (done && !load) ? 1'b1 : overflow;
    end
endmodule

// File: tb/tb_serial_deser.sv
// tb_serial_deser: directed scoreboard bench driving MSB-first and LSB-first instances in lockstep
module tb_serial_deser;
  logic clk = 1'b0;
  logic rst, d, en, sync_clr, out_ready;
  logic [7:0] dm, dl;
  logic vm, vl, om, ol, pm, pl;
  typedef struct {logic [7:0] m; logic [7:0] l; logic pe;} exp_t;
  exp_t exp_q[$];
  exp_t cur;
  int total = 0;
  int bad = 0;
`ifdef SERIAL_DESER_PARITY_EN
  localparam int FB = 9;
`else
  localparam int FB = 8;
`endif

  always #5 clk = ~clk;

  serial_deser #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst(rst), .d(d), .en(en), .sync_clr(sync_clr), .data_out(dm),
    .out_valid(vm), .out_ready(out_ready), .overflow(om), .parity_err(pm)
  );
  serial_deser #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .d(d), .en(en), .sync_clr(sync_clr), .data_out(dl),
    .out_valid(vl), .out_ready(out_ready), .overflow(ol), .parity_err(pl)
  );

  function automatic logic [7:0] rev8(input logic [7:0] w);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = w[7 - i];
    return r;
  endfunction

  function automatic logic [8:0] frame(input logic [7:0] w, input logic p);
    return (FB == 9) ? {w, p} : {1'b0, w};
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic bd, input logic be);
    d = bd;
    en = be;
    @(negedge clk);
  endtask

  task automatic send(input logic [7:0] w, input logic p, input logic rdy_last);
    logic [8:0] f;
    logic keep;
    f = frame(w, p);
    keep = out_ready;
    for (int i = FB - 1; i >= 0; i--) begin
      if (i == 0 && rdy_last) out_ready = 1'b1;
      cyc(f[i], 1'b1);
    end
    out_ready = keep;
    en = 1'b0;
  endtask

  task automatic push(input logic [7:0] w, input logic p);
    exp_t e;
    e.m = w;
    e.l = rev8(w);
    e.pe = (FB == 9) ? (^w ^ p) : 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic chk_hold(input string tag);
    chk({tag, "_valid_m"}, {7'd0, vm}, 8'd1);
    chk({tag, "_valid_l"}, {7'd0, vl}, 8'd1);
    chk({tag, "_data_m"}, dm, cur.m);
    chk({tag, "_data_l"}, dl, cur.l);
    chk({tag, "_perr_m"}, {7'd0, pm}, {7'd0, cur.pe});
    chk({tag, "_perr_l"}, {7'd0, pl}, {7'd0, cur.pe});
  endtask

  task automatic expect_word(input string tag);
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s observed=word expected=empty_scoreboard", tag);
    end else begin
      cur = exp_q.pop_front();
      chk_hold(tag);
    end
  endtask

  initial begin
    logic [8:0] f;
    rst = 1'b0; d = 1'b0; en = 1'b0; sync_clr = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_valid_m", {7'd0, vm}, 8'd0);
    chk("rst_valid_l", {7'd0, vl}, 8'd0);
    chk("rst_data_m", dm, 8'd0);
    chk("rst_data_l", dl, 8'd0);
    chk("rst_ovf", {7'd0, om}, 8'd0);
    chk("rst_perr", {7'd0, pm}, 8'd0);
    rst = 1'b1;
    cyc(1'b1, 1'b1); cyc(1'b1, 1'b1); cyc(1'b0, 1'b1);
    #2 rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    push(8'hA5, 1'b0);
    send(8'hA5, 1'b0, 1'b0);
    expect_word("rst_a5");
    chk("rst_a5_ovf", {7'd0, om}, 8'd0);
    cyc(1'b0, 1'b0);
    chk_hold("hold_a5");
    out_ready = 1'b1;
    cyc(1'b0, 1'b0);
    out_ready = 1'b0;
    chk("drain_valid", {7'd0, vm}, 8'd0);
    push(8'hA5, 1'b0);
    f = frame(8'hA5, 1'b0);
    for (int i = FB - 1; i >= 0; i--) begin
      cyc(f[i], 1'b1);
      if (i == 1) chk("gate_mid_valid", {7'd0, vm}, 8'd0);
      cyc(~f[i], 1'b0);
    end
    expect_word("gate_a5");
    send(8'h3C, 1'b0, 1'b0);
    chk_hold("bp_hold");
    chk("bp_ovf_m", {7'd0, om}, 8'd1);
    chk("bp_ovf_l", {7'd0, ol}, 8'd1);
    cyc(1'b1, 1'b1); cyc(1'b1, 1'b1); cyc(1'b1, 1'b1);
    sync_clr = 1'b1;
    cyc(1'b1, 1'b1);
    sync_clr = 1'b0;
    chk("clr_ovf", {7'd0, om}, 8'd0);
    chk_hold("clr_hold");
    push(8'h3C, 1'b0);
    send(8'h3C, 1'b0, 1'b1);
    expect_word("simul_3c");
    chk("simul_ovf", {7'd0, om}, 8'd0);
    out_ready = 1'b1;
    cyc(1'b0, 1'b0);
    chk("drain2_valid", {7'd0, vm}, 8'd0);
    push(8'hF0, 1'b0);
    send(8'hF0, 1'b0, 1'b0);
    expect_word("b2b_f0");
    push(8'h96, 1'b0);
    send(8'h96, 1'b0, 1'b0);
    expect_word("b2b_96");
    chk("b2b_ovf", {7'd0, om}, 8'd0);
    out_ready = 1'b0;
`ifdef SERIAL_DESER_PARITY_EN
    out_ready = 1'b1;
    cyc(1'b0, 1'b0);
    out_ready = 1'b0;
    push(8'hA5, 1'b1);
    send(8'hA5, 1'b1, 1'b0);
    expect_word("par_err_a5");
`endif
    #2 rst = 1'b0;
    #1;
    chk("async_valid", {7'd0, vm}, 8'd0);
    chk("async_data", dm, 8'd0);
    @(negedge clk);
    rst = 1'b1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end
endmodule

// File: doc/serial_deser.md
# serial_deser

Serial-to-parallel deserializer that sits directly downstream of the enabled D flip-flop stage. It consumes the flop's registered single-bit output `q` (wired to `d` here) together with the same enable qualifier. Qualified bits are assembled into WIDTH-bit words, and each completed word is presented on a registered parallel output under a valid/ready handshake. A sticky flag reports words lost to back-pressure.

## Interface
- `WIDTH`, 8: data bits per word; legal range 2..32.
- `MSB_FIRST`, 1: 1 = first received bit lands in `data_out[WIDTH-1]`; 0 = first bit lands in `data_out[0]`.

- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  reset; asynchronous, active-low; clears all state.
- `d`  in  1  serial bit, driven by the upstream flop's `q`.
- `en`  in  1  bit qualifier; `d` is sampled only on edges where `en`=1.
- `sync_clr`  in  1  synchronous discard of the partially assembled word.
- `data_out`  out  WIDTH  last completed word.
- `out_valid`  out  1  `data_out` holds an unconsumed word.
- `out_ready`  in  1  consumer accepts the word.
- `overflow`  out  1  sticky flag: a completed word was dropped.
- `parity_err`  out  1  per-word parity error; qualified by `out_valid`.

## Operation
- Reset (`rst`=0, asynchronous) clears `data_out`, `out_valid`, `overflow`, `parity_err`, the shift register and the bit counter. The FSM returns to S_DATA.
- FSM states:
  - S_DATA: each edge with `en`=1 shifts `d` in and increments `bit_cnt`. The edge that samples bit WIDTH-1 completes the word. Without the parity feature, S_DATA stays the state.
  - S_PAR: compiled in only with the parity feature. The next `en`=1 edge samples the parity bit, completes the word and returns to S_DATA.
- Word completion, decided at the completing edge:
  - Output free (`out_valid`=0), or the current word is being accepted this edge (`out_valid`=1 and `out_ready`=1): load `data_out`/`parity_err` and set `out_valid`=1.
  - Output busy and not accepted: drop the new word, keep the old word, set `overflow`=1.
- Handshake:
  - A transfer occurs on an edge where `out_valid`=1 and `out_ready`=1.
  - After a transfer with no simultaneous completion, `out_valid` goes to 0.
  - `data_out` is held stable while `out_valid`=1.
- `sync_clr`=1 has priority over `en` on the same edge. It clears the shift register and `bit_cnt`, returns the FSM to S_DATA and clears `overflow`. It does not touch `data_out`, `out_valid` or `parity_err`. A transfer on the same edge still completes.
- `en`=0 edges freeze the shift register and counter indefinitely; a partial word is retained.
- `bit_cnt` width is $clog2(WIDTH+1). It wraps to 0 on word completion, with no skipped or duplicated bits across back-to-back words.

## Timing
- Sampling: `d` is captured at the rising edge with `en`=1. Back-to-back words at full rate (`en` held 1) are supported.
- Latency: `out_valid` and `data_out` update at the same edge that samples the last bit of the frame (the data bit, or the parity bit when the feature is compiled in). They are visible immediately after that edge.
- Throughput: one word per WIDTH qualified edges, or WIDTH+1 with parity. `out_ready` may be held 1 permanently.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- Macro: `SERIAL_DESER_PARITY_EN`.
- Defined:
  - Each frame is WIDTH data bits followed by one even-parity bit.
  - `parity_err` = XOR of all WIDTH+1 received bits, registered with the word.
  - A word with a parity error is still delivered.
- Undefined:
  - S_PAR is not generated and frames are WIDTH bits.
  - `parity_err` is tied to 0.
  - The port list is identical in both builds.

## Structure
- Package `serial_deser_pkg`:
  - `deser_state_e` enum {S_DATA, S_PAR}.
  - `DESER_WIDTH_DEF`=8.
  - Function `cnt_width(int w)` returning $clog2(w+1).
- Sub-module `deser_shifter`:
  - Parameterized WIDTH/MSB_FIRST shift register with `shift_en` and `clr` inputs.
  - The top level holds the FSM, bit counter and output holding register.

## Test plan
- Reset: drive `rst`=0 mid-word after 3 bits, then release and send bits 1,0,1,0,0,1,0,1 with `en`=1 → partial bits discarded; `data_out`=8'hA5, `out_valid`=1, `overflow`=0.
- Enable gating: same 8 bits with `en` toggled 1,0 each cycle and `d` flipped on the `en`=0 cycles → `data_out`=8'hA5 after 8 qualified edges only.
- Back-pressure: `out_ready`=0 with two words 8'hA5 then 8'h3C → `data_out` stays 8'hA5, `overflow`=1. Then `sync_clr`=1 for one cycle → `overflow`=0, `out_valid` still 1.
- Simultaneous accept and complete: `out_ready` pulsed at the edge completing 8'h3C while 8'hA5 is pending → `data_out`=8'h3C, `out_valid` stays 1, `overflow`=0.
- `MSB_FIRST`=0: bits 1,0,1,0,0,1,0,1 → `data_out`=8'hA5 bit-reversed = 8'hA5 (palindrome). Then bits 1,1,1,1,0,0,0,0 → `data_out`=8'h0F.
- With `SERIAL_DESER_PARITY_EN`:
  - 8'hA5 followed by parity 0 → `parity_err`=0.
  - 8'hA5 followed by parity 1 → word 8'hA5 delivered with `parity_err`=1.
